// File: rtl/sigmoid_bist_pkg.sv
// Shared widths and FSM state type for the sigmoid BIST stimulus/checker.
package sigmoid_bist_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 16;
  localparam int unsigned SQ_W  = 32;
  localparam int unsigned ACC_W = 40;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    COLLECT,
    FIN,
    DONE
  } state_e;

endpackage

// File: rtl/sigmoid_err_acc.sv
// Registers an accepted result, then adds its squared error against the ROM word
// that arrives one cycle later to a 40-bit accumulator.
module sigmoid_err_acc
  import sigmoid_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [Y_W-1:0]   y_i,
  input  logic [Y_W-1:0]   gold_i,
  output logic [ACC_W-1:0] acc_o
);

  logic             vld_q, vld_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [Y_W-1:0]   diff_c;
  logic [SQ_W-1:0]  sq_c;

  // gold_i holds mem[j] in the cycle after result j was captured into y_q
  always_comb begin
    diff_c = (y_q >= gold_i) ? (y_q - gold_i) : (gold_i - y_q);
    sq_c   = SQ_W'(diff_c) * SQ_W'(diff_c);
    vld_d  = valid_i;
    y_d    = valid_i ? y_i : y_q;
    acc_d  = vld_q ? (acc_q + ACC_W'(sq_c)) : acc_q;
    if (clear_i) begin
      vld_d = 1'b0;
      y_d   = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      y_q   <= '0;
      acc_q <= '0;
    end else begin
      vld_q <= vld_d;
      y_q   <= y_d;
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sigmoid_bist.sv
// Drives every input code into the sigmoid datapath, collects its result stream
// and measures squared error, latency and cycle count against a golden ROM.
module sigmoid_bist
  import sigmoid_bist_pkg::*;
#(
  parameter int unsigned N_PAT   = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err_gap,
  output logic             err_timeout,
  output logic [X_W-1:0]   dut_x,
  output logic             dut_in_valid,
  input  logic             dut_out_valid,
  input  logic [Y_W-1:0]   dut_y,
  output logic [X_W-1:0]   gold_addr,
  input  logic [Y_W-1:0]   gold_data,
  output logic [ACC_W-1:0] mse_acc,
  output logic [31:0]      score,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] latency
);

  localparam int unsigned CNTX_W = CNT_W + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] feed_cnt_q, feed_cnt_d;
  logic [X_W-1:0]   dut_x_q, dut_x_d;
  logic             in_vld_q, in_vld_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             seen_q, seen_d;
  logic             err_gap_q, err_gap_d;
  logic             err_to_q, err_to_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic              acc_clr_c;
  logic              accept_c;
  logic              last_acc_c;
  logic              gap_c;
  logic              tout_c;
  logic [CNTX_W-1:0] cyc_inc_c;

  always_comb begin
    state_d    = state_q;
    feed_cnt_d = feed_cnt_q;
    dut_x_d    = dut_x_q;
    in_vld_d   = in_vld_q;
    res_cnt_d  = res_cnt_q;
    cyc_d      = cyc_q;
    lat_d      = lat_q;
    seen_d     = seen_q;
    err_gap_d  = err_gap_q;
    err_to_d   = err_to_q;
    acc_clr_c  = 1'b0;
    accept_c   = 1'b0;
    last_acc_c = 1'b0;
    gap_c      = 1'b0;
    tout_c     = 1'b0;
    cyc_inc_c  = {1'b0, cyc_q} + CNTX_W'(1);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FEED;
          feed_cnt_d = '0;
          dut_x_d    = '0;
          in_vld_d   = 1'b1;
          res_cnt_d  = '0;
          cyc_d      = '0;
          lat_d      = '0;
          seen_d     = 1'b0;
          err_gap_d  = 1'b0;
          err_to_d   = 1'b0;
          acc_clr_c  = 1'b1;
        end
      end
      FEED, COLLECT: begin
        cyc_d      = cyc_q + CNT_W'(1);
        accept_c   = dut_out_valid;
        last_acc_c = dut_out_valid && (res_cnt_q == CNT_W'(N_PAT - 1));
        gap_c      = seen_q && !dut_out_valid;
        // Accepting the final result on the budget edge still counts as on time
        tout_c     = (cyc_inc_c >= CNTX_W'(TIMEOUT)) && !last_acc_c;
        if (accept_c) begin
          res_cnt_d = res_cnt_q + CNT_W'(1);
          seen_d    = 1'b1;
          if (!seen_q) begin
            lat_d = cyc_q;
          end
        end
        if (state_q == FEED) begin
          if (feed_cnt_q == CNT_W'(N_PAT - 1)) begin
            state_d  = COLLECT;
            in_vld_d = 1'b0;
            dut_x_d  = '0;
          end else begin
            feed_cnt_d = feed_cnt_q + CNT_W'(1);
            dut_x_d    = X_W'(feed_cnt_q + CNT_W'(1));
          end
        end
        if (last_acc_c) begin
          state_d = FIN;
        end
        if (gap_c || tout_c) begin
          state_d   = DONE;
          in_vld_d  = 1'b0;
          dut_x_d   = '0;
          err_gap_d = err_gap_q | gap_c;
          err_to_d  = err_to_q | tout_c;
        end
      end
      FIN: state_d = DONE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FEED) || (state_d == COLLECT) || (state_d == FIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      feed_cnt_q <= '0;
      dut_x_q    <= '0;
      in_vld_q   <= 1'b0;
      res_cnt_q  <= '0;
      cyc_q      <= '0;
      lat_q      <= '0;
      seen_q     <= 1'b0;
      err_gap_q  <= 1'b0;
      err_to_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      feed_cnt_q <= feed_cnt_d;
      dut_x_q    <= dut_x_d;
      in_vld_q   <= in_vld_d;
      res_cnt_q  <= res_cnt_d;
      cyc_q      <= cyc_d;
      lat_q      <= lat_d;
      seen_q     <= seen_d;
      err_gap_q  <= err_gap_d;
      err_to_q   <= err_to_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  sigmoid_err_acc u_err_acc (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clr_c),
    .valid_i (accept_c),
    .y_i     (dut_y),
    .gold_i  (gold_data),
    .acc_o   (mse_acc)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_gap      = err_gap_q;
  assign err_timeout  = err_to_q;
  assign dut_x        = dut_x_q;
  assign dut_in_valid = in_vld_q;
  assign gold_addr    = res_cnt_q[X_W-1:0];
  assign score        = mse_acc[ACC_W-1:8];
  assign cycles       = cyc_q;
  assign latency      = lat_q;

endmodule

// File: tb/tb_sigmoid_bist.sv
// Bench for sigmoid_bist: behavioural datapath with configurable latency/errors,
// golden ROM, and an error-sum model derived from the stream rules.
module tb_sigmoid_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err_gap, err_timeout;
  logic [7:0]  dut_x, gold_addr;
  logic        dut_in_valid, dut_out_valid;
  logic [15:0] dut_y, gold_data;
  logic [39:0] mse_acc;
  logic [31:0] score;
  logic [15:0] cycles, latency;

  always #5 clk = ~clk;

  sigmoid_bist dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .err_gap       (err_gap),
    .err_timeout   (err_timeout),
    .dut_x         (dut_x),
    .dut_in_valid  (dut_in_valid),
    .dut_out_valid (dut_out_valid),
    .dut_y         (dut_y),
    .gold_addr     (gold_addr),
    .gold_data     (gold_data),
    .mse_acc       (mse_acc),
    .score         (score),
    .cycles        (cycles),
    .latency       (latency)
  );

  // Golden table and per-code error the modelled datapath adds to it
  logic [15:0] gmem    [256];
  logic [15:0] err_tab [256];
  int          cfg_lat = 3;
  int          cfg_gap = -1;
  int          cfg_noval = 0;

  logic        pv [8];
  logic [15:0] py [8];
  logic [7:0]  px [8];
  logic        rv;
  logic [15:0] ry;
  logic [7:0]  rx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        pv[i] <= 1'b0;
        py[i] <= '0;
        px[i] <= '0;
      end
    end else begin
      pv[0] <= dut_in_valid;
      py[0] <= gmem[dut_x] + err_tab[dut_x];
      px[0] <= dut_x;
      for (int i = 1; i < 8; i++) begin
        pv[i] <= pv[i-1];
        py[i] <= py[i-1];
        px[i] <= px[i-1];
      end
    end
  end

  always_comb begin
    if (cfg_lat == 0) begin
      rv = dut_in_valid;
      ry = gmem[dut_x] + err_tab[dut_x];
      rx = dut_x;
    end else begin
      rv = pv[cfg_lat-1];
      ry = py[cfg_lat-1];
      rx = px[cfg_lat-1];
    end
    dut_out_valid = rv && (cfg_noval == 0) && !(cfg_gap >= 0 && int'(rx) == cfg_gap);
    dut_y = ry;
  end

  always @(posedge clk) gold_data <= gmem[gold_addr];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] hsh(input int unsigned s, input int unsigned k);
    int unsigned h;
    h = s * 32'd1103515245 + k * 32'd12345 + 32'h9E37;
    h = h ^ (h >> 13);
    h = h * 32'd2654435761;
    return h[31:16];
  endfunction

  // Sum of squared magnitudes over the first n results of the stream
  function automatic longint model_mse(input int n);
    longint s;
    logic [15:0] y, g, d;
    s = 0;
    for (int k = 0; k < n; k++) begin
      g = gmem[k];
      y = gmem[k] + err_tab[k];
      d = (y >= g) ? (y - g) : (g - y);
      s += longint'(64'(d) * 64'(d));
    end
    return s;
  endfunction

  typedef struct {
    int lat;
    int off;
    int rnd;
    int seed;
    int gap;
    int noval;
    int mid;
    int exp_mse;
  } vec_t;

  vec_t vecs [11];

  task automatic load_cfg(input vec_t v);
    cfg_lat   = v.lat;
    cfg_gap   = v.gap;
    cfg_noval = v.noval;
    for (int k = 0; k < 256; k++)
      err_tab[k] = (v.rnd != 0) ? hsh(v.seed, k) : 16'(v.off);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int     n;
    int     n_acc;
    int     exp_n;
    longint em;
    load_cfg(v);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_run"}, 64'(busy), 64'(1));
    chk({tag, ".done_clr"}, 64'(done), 64'(0));
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      start = (v.mid != 0 && n == 20);
    end
    start = 1'b0;
    n_acc = (v.noval != 0) ? 0 : ((v.gap >= 0) ? v.gap : 256);
    exp_n = (v.noval != 0) ? 1024 : ((v.gap >= 0) ? v.gap + v.lat + 1 : 257 + v.lat);
    em    = (v.exp_mse >= 0) ? longint'(v.exp_mse) : model_mse(n_acc);
    chk({tag, ".done"}, 64'(done), 64'(1));
    chk({tag, ".done_time"}, longint'(n), longint'(exp_n));
    chk({tag, ".busy_end"}, 64'(busy), 64'(0));
    chk({tag, ".err_gap"}, 64'(err_gap), longint'(v.gap >= 0));
    chk({tag, ".err_timeout"}, 64'(err_timeout), longint'(v.noval));
    chk({tag, ".mse"}, 64'(mse_acc), em);
    chk({tag, ".score"}, 64'(score), em >> 8);
    chk({tag, ".latency"}, 64'(latency), (v.noval != 0) ? 64'(0) : longint'(v.lat));
    if (v.gap < 0)
      chk({tag, ".cycles"}, 64'(cycles), (v.noval != 0) ? 64'(1024) : longint'(256 + v.lat));
    chk({tag, ".in_valid_idle"}, 64'(dut_in_valid), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".errs"}, 64'({err_gap, err_timeout}), 64'(0));
    chk({tag, ".x_vld"}, 64'({dut_x, dut_in_valid}), 64'(0));
    chk({tag, ".mse_score"}, 64'(mse_acc) + 64'(score), 64'(0));
    chk({tag, ".cyc_lat_addr"}, 64'({cycles, latency, gold_addr}), 64'(0));
  endtask

  initial begin
    vec_t rv_vec;
    for (int k = 0; k < 256; k++) begin
      gmem[k]    = 16'($urandom_range(0, 32'hFF00));
      err_tab[k] = '0;
    end
    //         lat off rnd seed gap noval mid exp_mse
    vecs[0]  = '{3, 0,  0, 0,  -1,  0, 0, 0};
    vecs[1]  = '{3, 1,  0, 0,  -1,  0, 0, 256};
    vecs[2]  = '{3, 16, 0, 0,  -1,  0, 0, 65536};
    vecs[3]  = '{3, 1,  0, 0,  100, 0, 0, 100};
    vecs[4]  = '{3, 0,  0, 0,  -1,  1, 0, 0};
    vecs[5]  = '{0, 0,  1, 11, -1,  0, 0, -1};
    vecs[6]  = '{5, 0,  1, 22, -1,  0, 1, -1};
    vecs[7]  = '{5, 0,  1, 22, -1,  0, 0, -1};
    vecs[8]  = '{0, 0,  1, 33, 37,  0, 0, -1};
    vecs[9]  = '{7, 0,  1, 44, 255, 0, 0, -1};
    vecs[10] = '{7, 16, 0, 0,  -1,  0, 0, 65536};

    #1 rst = 1'b1;
    #3 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-feed clears outputs before any clock edge
    load_cfg(vecs[0]);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("midrst.busy_before", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], "after_rst");

    for (int r = 0; r < 4; r++) begin
      rv_vec.lat     = int'($urandom_range(0, 7));
      rv_vec.off     = 0;
      rv_vec.rnd     = 1;
      rv_vec.seed    = int'($urandom);
      rv_vec.gap     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : -1;
      rv_vec.noval   = 0;
      rv_vec.mid     = int'($urandom_range(0, 1));
      rv_vec.exp_mse = -1;
      run_vec(rv_vec, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
